// File: rtl/sram_config_loader.sv
// Boot-time loader: reads a magic byte and a config byte from SRAM, then holds the machine in reset.
// Optional macro SRAM_CFG_KBD_TOGGLE_EN lets a keyboard request toggle vga_on once running.
module sram_config_loader #(
  parameter logic [18:0] CFG_ADDR    = 19'h7FF00,
  parameter logic [7:0]  CFG_MAGIC   = 8'hC3,
  parameter logic [7:0]  DEFAULT_CFG = 8'h00,
  parameter int          WAIT_STATES = 2,
  parameter int          HOLD_CYCLES = 16000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [18:0] sram_addr,
  input  logic [7:0]  sram_data,
  output logic        sram_we_n,
  output logic        cfg_busy,
  output logic        pwon_reset_n,
  output logic        vga_on,
  output logic        scanlines_on,
  input  logic        kbd_scandoubler
);

  typedef enum logic [1:0] {
    RD_MAGIC = 2'd0,
    RD_CFG   = 2'd1,
    HOLD     = 2'd2,
    RUN      = 2'd3
  } state_t;

  localparam int WW = (WAIT_STATES > 0) ? $clog2(WAIT_STATES + 1) : 1;
  localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
  localparam logic [WW-1:0] WAIT_LAST = WW'(WAIT_STATES);
  localparam logic [HW-1:0] HOLD_LAST = (HOLD_CYCLES > 0) ? HW'(HOLD_CYCLES - 1) : '0;
  localparam logic [18:0]   CFG_DATA_ADDR = CFG_ADDR + 19'd1;

  state_t        state_q, state_d;
  logic [WW-1:0] wait_cnt_q, wait_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic [7:0]    magic_q, magic_d;
  logic [18:0]   sram_addr_q, sram_addr_d;
  logic          pwon_q, pwon_d;
  logic          busy_q, busy_d;
  logic          vga_q, vga_d;
  logic          scan_q, scan_d;
  logic          kbd_rise_s;

`ifdef SRAM_CFG_KBD_TOGGLE_EN
  logic kbd_prev_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      kbd_prev_q <= 1'b0;
    end else begin
      kbd_prev_q <= kbd_scandoubler;
    end
  end

  // Rises seen before RUN are simply never acted on; the history still tracks every cycle.
  assign kbd_rise_s = kbd_scandoubler & ~kbd_prev_q;
`else
  logic unused_kbd_s;
  assign unused_kbd_s = kbd_scandoubler;
  assign kbd_rise_s   = 1'b0;
`endif

  always_comb begin
    state_d     = state_q;
    wait_cnt_d  = wait_cnt_q;
    hold_cnt_d  = hold_cnt_q;
    magic_d     = magic_q;
    sram_addr_d = sram_addr_q;
    pwon_d      = pwon_q;
    busy_d      = busy_q;
    vga_d       = vga_q;
    scan_d      = scan_q;
    case (state_q)
      RD_MAGIC: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d  = '0;
          magic_d     = sram_data;
          sram_addr_d = CFG_DATA_ADDR;
          state_d     = RD_CFG;
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      RD_CFG: begin
        if (wait_cnt_q == WAIT_LAST) begin
          wait_cnt_d = '0;
          if (magic_q == CFG_MAGIC) begin
            vga_d  = sram_data[0];
            scan_d = sram_data[1];
          end else begin
            vga_d  = DEFAULT_CFG[0];
            scan_d = DEFAULT_CFG[1];
          end
          if (HOLD_CYCLES == 0) begin
            state_d = RUN;
            pwon_d  = 1'b1;
            busy_d  = 1'b0;
          end else begin
            state_d = HOLD;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + WW'(1);
        end
      end
      HOLD: begin
        if (hold_cnt_q == HOLD_LAST) begin
          hold_cnt_d = '0;
          state_d    = RUN;
          pwon_d     = 1'b1;
          busy_d     = 1'b0;
        end else begin
          hold_cnt_d = hold_cnt_q + HW'(1);
        end
      end
      RUN: begin
        if (kbd_rise_s) begin
          vga_d = ~vga_q;
        end else begin
          vga_d = vga_q;
        end
      end
      default: begin
        state_d = RD_MAGIC;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RD_MAGIC;
      wait_cnt_q  <= '0;
      hold_cnt_q  <= '0;
      magic_q     <= 8'h00;
      sram_addr_q <= CFG_ADDR;
      pwon_q      <= 1'b0;
      busy_q      <= 1'b1;
      vga_q       <= 1'b0;
      scan_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wait_cnt_q  <= wait_cnt_d;
      hold_cnt_q  <= hold_cnt_d;
      magic_q     <= magic_d;
      sram_addr_q <= sram_addr_d;
      pwon_q      <= pwon_d;
      busy_q      <= busy_d;
      vga_q       <= vga_d;
      scan_q      <= scan_d;
    end
  end

  assign sram_addr    = sram_addr_q;
  assign sram_we_n    = 1'b1;
  assign cfg_busy     = busy_q;
  assign pwon_reset_n = pwon_q;
  assign vga_on       = vga_q;
  assign scanlines_on = scan_q;

endmodule

// File: tb/tb_sram_config_loader.sv
// Scoreboard bench for sram_config_loader: stimulus queues expected load/toggle events, a monitor checks them.
module tb_sram_config_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [7:0]  magic_b = 8'hC3;
  logic [7:0]  cfg_b   = 8'h03;
  logic        kbd = 1'b0;
  logic        kbd0 = 1'b1;

  logic [18:0] sram_addr, sram_addr0;
  logic [7:0]  sram_data, sram_data0;
  logic        sram_we_n, sram_we_n0;
  logic        cfg_busy, cfg_busy0;
  logic        pwon, pwon0;
  logic        vga, vga0;
  logic        scan, scan0;

  int tests = 0;
  int fails = 0;
  int ec = 0;

  typedef struct {
    bit   is_toggle;
    int   edge_n;
    logic vga;
    logic scan;
  } exp_t;
  exp_t q[$];

  always #5 clk = ~clk;

  assign sram_data  = (sram_addr  == 19'h7FF00) ? magic_b : (sram_addr  == 19'h7FF01) ? cfg_b : 8'hFF;
  assign sram_data0 = (sram_addr0 == 19'h7FF00) ? magic_b : (sram_addr0 == 19'h7FF01) ? cfg_b : 8'hFF;

  sram_config_loader #(.WAIT_STATES(2), .HOLD_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .sram_addr(sram_addr), .sram_data(sram_data),
    .sram_we_n(sram_we_n), .cfg_busy(cfg_busy), .pwon_reset_n(pwon),
    .vga_on(vga), .scanlines_on(scan), .kbd_scandoubler(kbd)
  );

  sram_config_loader #(.WAIT_STATES(0), .HOLD_CYCLES(0)) dut0 (
    .clk(clk), .rst(rst), .sram_addr(sram_addr0), .sram_data(sram_data0),
    .sram_we_n(sram_we_n0), .cfg_busy(cfg_busy0), .pwon_reset_n(pwon0),
    .vga_on(vga0), .scanlines_on(scan0), .kbd_scandoubler(kbd0)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Edge number since the last edge that sampled rst high.
  initial begin
    forever begin
      @(posedge clk);
      if (rst) ec = 0;
      else ec = ec + 1;
    end
  end

  // Monitor: a rising pwon_reset_n or a vga_on change in RUN pops one expected event.
  initial begin
    logic pwon_prev = 1'b0;
    logic vga_prev  = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!pwon_prev && pwon) begin
        if (q.size() == 0) begin
          check("unexpected_load", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("load_kind", {31'd0, e.is_toggle}, 32'd0);
          check("load_latency", ec, e.edge_n);
          check("load_vga", {31'd0, vga}, {31'd0, e.vga});
          check("load_scan", {31'd0, scan}, {31'd0, e.scan});
          check("load_busy", {31'd0, cfg_busy}, 32'd0);
        end
      end else if (pwon_prev && pwon && (vga !== vga_prev)) begin
        if (q.size() == 0) begin
          check("unexpected_toggle", 32'd1, 32'd0);
        end else begin
          e = q.pop_front();
          check("toggle_kind", {31'd0, e.is_toggle}, 32'd1);
          check("toggle_edge", ec, e.edge_n);
          check("toggle_vga", {31'd0, vga}, {31'd0, e.vga});
        end
      end
      pwon_prev = pwon;
      vga_prev  = vga;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push_load(input int edge_n, input logic v, input logic s);
    exp_t e;
    e.is_toggle = 1'b0; e.edge_n = edge_n; e.vga = v; e.scan = s;
    q.push_back(e);
  endtask

  task automatic push_toggle(input int edge_n, input logic v);
    exp_t e;
    e.is_toggle = 1'b1; e.edge_n = edge_n; e.vga = v; e.scan = 1'b0;
    q.push_back(e);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    check("rst_addr", {13'd0, sram_addr}, 32'h7FF00);
    check("rst_pwon", {31'd0, pwon}, 32'd0);
    check("rst_busy", {31'd0, cfg_busy}, 32'd1);
    check("rst_vga", {31'd0, vga}, 32'd0);
    check("rst_scan", {31'd0, scan}, 32'd0);
    check("rst_we_n", {31'd0, sram_we_n}, 32'd1);
    check("rst0_pwon", {31'd0, pwon0}, 32'd0);
    check("rst0_vga", {31'd0, vga0}, 32'd0);

    // Valid load, with a keyboard pulse during HOLD that must be ignored.
    push_load(10, 1'b1, 1'b1);
    rst = 1'b0;
    for (int e = 1; e <= 14; e++) begin
      @(negedge clk);
      case (e)
        1: check("corner_pwon_e1", {31'd0, pwon0}, 32'd0);
        2: begin
          check("corner_pwon_e2", {31'd0, pwon0}, 32'd1);
          check("corner_busy_e2", {31'd0, cfg_busy0}, 32'd0);
          check("corner_vga_e2", {31'd0, vga0}, 32'd1);
          check("corner_scan_e2", {31'd0, scan0}, 32'd1);
        end
        4: check("rdcfg_addr", {13'd0, sram_addr}, 32'h7FF01);
        6: kbd = 1'b1;
        8: kbd = 1'b0;
        9: begin
          check("hold_pwon", {31'd0, pwon}, 32'd0);
          check("hold_busy", {31'd0, cfg_busy}, 32'd1);
        end
        12: begin
          check("corner_vga_held", {31'd0, vga0}, 32'd1);
          check("run_addr", {13'd0, sram_addr}, 32'h7FF01);
          check("run_we_n", {31'd0, sram_we_n}, 32'd1);
        end
        default: ;
      endcase
    end
    check("pending_load_valid", q.size(), 32'd0);

    // Two keyboard pulses in RUN.
`ifdef SRAM_CFG_KBD_TOGGLE_EN
    push_toggle(ec + 1, 1'b0);
`endif
    kbd = 1'b1;
    @(negedge clk); kbd = 1'b0;
    repeat (2) @(negedge clk);
`ifdef SRAM_CFG_KBD_TOGGLE_EN
    check("vga_after_pulse1", {31'd0, vga}, 32'd0);
    push_toggle(ec + 1, 1'b1);
`else
    check("vga_after_pulse1", {31'd0, vga}, 32'd1);
`endif
    kbd = 1'b1;
    @(negedge clk); kbd = 1'b0;
    repeat (3) @(negedge clk);
    check("vga_after_pulse2", {31'd0, vga}, 32'd1);
    check("pending_toggle", q.size(), 32'd0);

    // Bad magic falls back to DEFAULT_CFG.
    rst = 1'b1; magic_b = 8'h00;
    repeat (2) @(negedge clk);
    push_load(10, 1'b0, 1'b0);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    check("pending_load_bad", q.size(), 32'd0);

    // Reset pulse in the middle of RD_CFG restarts the sequence.
    rst = 1'b1; magic_b = 8'hC3;
    repeat (2) @(negedge clk);
    push_load(10, 1'b1, 1'b1);
    rst = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_addr", {13'd0, sram_addr}, 32'h7FF00);
    check("midrst_pwon", {31'd0, pwon}, 32'd0);
    rst = 1'b0;
    repeat (14) @(negedge clk);
    check("pending_load_midrst", q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/sram_config_loader.md
SRAM_CONFIG_LOADER -- requirements
Module: sram_config_loader

Interface
REQ-001 SHALL provide parameter CFG_ADDR, default 19'h7FF00, SRAM address of the magic byte; the config byte is at CFG_ADDR+1.
REQ-002 SHALL provide parameter CFG_MAGIC, default 8'hC3, the value that marks the config byte as valid.
REQ-003 SHALL provide parameter DEFAULT_CFG, default 8'h00, the config byte used when the magic does not match.
REQ-004 SHALL provide parameter WAIT_STATES, default 2, the SRAM settle cycles before each sample.
REQ-005 SHALL provide parameter HOLD_CYCLES, default 16000, the cycles pwon_reset_n stays low after the load.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; one clock; reset is synchronous and active-high.
REQ-007 SHALL have port rst, input, 1 bit: synchronous active-high reset.
REQ-008 SHALL have port sram_addr, output, 19 bits: SRAM address while loading.
REQ-009 SHALL have port sram_data, input, 8 bits: SRAM read data.
REQ-010 SHALL have port sram_we_n, output, 1 bit: SRAM write enable, constant 1.
REQ-011 SHALL have port cfg_busy, output, 1 bit: the loader owns the SRAM bus; the top level muxes on it.
REQ-012 SHALL have port pwon_reset_n, output, 1 bit: machine reset, active low.
REQ-013 SHALL have port vga_on, output, 1 bit: scandoubler enable.
REQ-014 SHALL have port scanlines_on, output, 1 bit: scanline effect enable.
REQ-015 SHALL have port kbd_scandoubler, input, 1 bit: keyboard request to toggle the scandoubler.

Function
REQ-016 SHALL implement the state sequence RD_MAGIC -> RD_CFG -> HOLD -> RUN; RUN is terminal until rst.
REQ-017 RD_MAGIC SHALL drive sram_addr=CFG_ADDR and RD_CFG SHALL drive sram_addr=CFG_ADDR+1, computed 19-bit with wrap at 19'h7FFFF.
REQ-018 Each read state SHALL last WAIT_STATES+1 cycles and sample sram_data on its final edge; WAIT_STATES=0 means a one-cycle state.
REQ-019 On leaving RD_CFG, if the magic byte equals CFG_MAGIC, the outputs SHALL take vga_on=cfg[0] and scanlines_on=cfg[1]; otherwise they SHALL take the same bits of DEFAULT_CFG.
REQ-020 HOLD SHALL last HOLD_CYCLES cycles; HOLD_CYCLES=0 SHALL go directly from RD_CFG to RUN.
REQ-021 On entering RUN, pwon_reset_n SHALL go to 1 and cfg_busy SHALL go to 0, both registered.
REQ-022 Total latency SHALL be 2*(WAIT_STATES+1)+HOLD_CYCLES clock edges from the first edge with rst=0 to pwon_reset_n=1.
REQ-023 sram_addr SHALL hold CFG_ADDR+1 during HOLD and RUN.
REQ-024 sram_we_n SHALL be 1 at all times.
REQ-025 The previous value of kbd_scandoubler SHALL be registered every cycle, in every state.
REQ-026 A rising edge of kbd_scandoubler SHALL toggle vga_on only in RUN; edges before RUN SHALL be discarded.
REQ-027 A level held high across the entry into RUN SHALL NOT toggle vga_on.
REQ-028 A toggle SHALL appear on vga_on one edge after the edge that detects the rise; consecutive rising edges each toggle vga_on.

Reset
REQ-029 While rst=1, the block SHALL hold state=RD_MAGIC, counters=0, sram_addr=CFG_ADDR, pwon_reset_n=0, cfg_busy=1, vga_on=0, scanlines_on=0, sram_we_n=1, and the kbd_scandoubler history=0.
REQ-030 rst asserted in any state, including mid-read or mid-HOLD, SHALL restart the full sequence and discard any partially read bytes.

Configuration
REQ-031 With macro SRAM_CFG_KBD_TOGGLE_EN defined, the block SHALL implement REQ-025 to REQ-028.
REQ-032 Without SRAM_CFG_KBD_TOGGLE_EN, kbd_scandoubler SHALL be ignored, vga_on SHALL change only per REQ-019, and the edge-detect register SHALL be absent.

Verification (WAIT_STATES=2, HOLD_CYCLES=4 unless stated)
REQ-033 Valid load: SRAM[7FF00]=C3, SRAM[7FF01]=03, release rst -> pwon_reset_n=1 at edge 10, vga_on=1, scanlines_on=1, cfg_busy=0.
REQ-034 Bad magic: SRAM[7FF00]=00, SRAM[7FF01]=03 -> vga_on=0 and scanlines_on=0 in RUN, with the same latency of 10 edges.
REQ-035 Mid-load reset: assert rst at edge 5 for 1 cycle -> sram_addr returns to 7FF00 and pwon_reset_n first rises 10 edges after the release.
REQ-036 Toggle (macro on): in RUN, pulse kbd_scandoubler 0->1->0 twice -> vga_on flips twice, each flip 1 edge after the rise; the same pulse during HOLD -> no change.
REQ-037 Corner (macro on): WAIT_STATES=0, HOLD_CYCLES=0, kbd_scandoubler held at 1 from reset -> pwon_reset_n=1 at edge 2 and vga_on is not toggled.
